// File: rtl/inst_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : inst_loader_pkg
//  Description : Shared types and helpers for the instruction-memory loader.
//  Revision    : 1.0 - initial release
// ============================================================================
package inst_loader_pkg;

    // Loader control states; CHECK is only reachable in checksum builds.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_e;

    localparam int WORD_BYTES = 4;

    // Word index to byte address of a 32-bit word-aligned memory.
    function automatic logic [31:0] word_to_byte_addr(input logic [31:0] word_idx);
        return word_idx << $clog2(WORD_BYTES);
    endfunction

endpackage : inst_loader_pkg
`default_nettype wire

// File: rtl/inst_loader_byte_packer.sv
`default_nettype none
// ============================================================================
//  Module      : inst_loader_byte_packer
//  Description : Byte packer. Collects four accepted bytes into a 32-bit
//                word, first byte in the least significant lane.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_loader_byte_packer
    import inst_loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_full
);

    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] word_q, word_d;

    // Next lane counter and word contents: clear restarts, accept inserts.
    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        if (clear) begin
            cnt_d  = 2'd0;
            word_d = 32'h0;
        end else if (accept) begin
            case (cnt_q)
                2'd0:    word_d[7:0]   = byte_in;
                2'd1:    word_d[15:8]  = byte_in;
                2'd2:    word_d[23:16] = byte_in;
                default: word_d[31:24] = byte_in;
            endcase
            cnt_d = cnt_q + 2'd1;
        end
    end

    // Lane counter and word register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q  <= 2'd0;
            word_q <= 32'h0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

    assign word      = word_q;
    // High on the accept that fills the last lane of the word.
    assign word_full = accept && (cnt_q == 2'(WORD_BYTES - 1));

endmodule : inst_loader_byte_packer
`default_nettype wire

// File: rtl/inst_loader.sv
`default_nettype none
// ============================================================================
//  Module      : inst_loader
//  Description : Boot-time loader. Receives a program as a byte stream,
//                packs it into words, writes consecutive instruction-memory
//                words and holds the CPU in reset until a load succeeds.
//                Optional: define INST_LOADER_CHECKSUM_EN to require a
//                trailing XOR checksum byte after the last word.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int          ADDR_WIDTH = 5,
    parameter logic [31:0] FILL_VALUE = 32'h00000000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   word_count,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic                  mem_we,
    output logic [31:0]           mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    // Memory capacity in words, expressed in the index width.
    localparam logic [ADDR_WIDTH:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_e                state_q, state_d;
    logic [ADDR_WIDTH:0]   index_q, index_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  done_q,  done_d;
    logic                  error_q, error_d;

    logic                  recv_accept;
    logic                  packer_clear;
    logic                  word_full;
    logic [31:0]           packed_word;
    logic                  idle_like;

`ifdef INST_LOADER_CHECKSUM_EN
    logic [7:0]            csum_q, csum_d;
`endif

    // No memory fill path exists in this block; the value is kept for
    // interface compatibility with integrations that pass it.
    logic unused_fill;
    assign unused_fill = ^FILL_VALUE;

    assign idle_like    = (state_q == IDLE) || (state_q == DONE);
    assign recv_accept  = byte_valid && (state_q == RECV);
    assign packer_clear = start && idle_like;

    inst_loader_byte_packer u_packer (
        .clock     (clock),
        .reset     (reset),
        .clear     (packer_clear),
        .accept    (recv_accept),
        .byte_in   (byte_in),
        .word      (packed_word),
        .word_full (word_full)
    );

    // Next-state and output decode for the load sequence.
    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        count_d    = count_q;
        done_d     = done_q;
        error_d    = error_q;
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        busy       = 1'b0;
        cpu_hold   = 1'b1;
`ifdef INST_LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                // Only a clean completed load releases the CPU.
                if (state_q == DONE) begin
                    cpu_hold = error_q;
                end
                if (start) begin
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    index_d = '0;
`ifdef INST_LOADER_CHECKSUM_EN
                    csum_d  = 8'h00;
`endif
                    if (word_count == '0) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else if (word_count > MAX_WORDS) begin
                        error_d = 1'b1;
                        state_d = DONE;
                    end else begin
                        count_d = word_count;
                        state_d = RECV;
                    end
                end
            end
            RECV: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
`ifdef INST_LOADER_CHECKSUM_EN
                if (recv_accept) begin
                    csum_d = csum_q ^ byte_in;
                end
`endif
                if (word_full) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                mem_we = 1'b1;
                busy   = 1'b1;
                // The index stays on the last word so the final address
                // never wraps past the top of memory.
                if ((index_q + 1'b1) == count_q) begin
`ifdef INST_LOADER_CHECKSUM_EN
                    state_d = CHECK;
`else
                    done_d  = 1'b1;
                    state_d = DONE;
`endif
                end else begin
                    index_d = index_q + 1'b1;
                    state_d = RECV;
                end
            end
`ifdef INST_LOADER_CHECKSUM_EN
            CHECK: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (byte_valid) begin
                    if (byte_in == csum_q) begin
                        done_d  = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                    state_d = DONE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            index_q <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            count_q <= count_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

`ifdef INST_LOADER_CHECKSUM_EN
    // Running XOR of every program byte accepted in this load.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            csum_q <= 8'h00;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

    assign mem_addr  = word_to_byte_addr(32'(index_q));
    assign mem_wdata = packed_word;
    assign done      = done_q;
    assign error     = error_q;

endmodule : inst_loader
`default_nettype wire
